// File: rtl/dmux8way16_frame.sv
// dmux8way16_frame: registered 1-to-8 word distributor with frame tracking.
// Words arrive over valid/ready and are steered into held lanes a..h, either by
// an auto-incrementing pointer or by an explicit selector. Once all eight
// distinct lanes are written, the block stalls until the consumer acks.
//
// Handshake: a word transfers on a rising edge where in_valid=1 and in_ready=1
// (and reset=0). in_ready depends only on state, never on in_valid. The
// producer must hold in/sel/auto stable while in_valid=1 and in_ready=0.
module dmux8way16_frame #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic             auto,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       load,
    output logic [2:0]       ptr,
    output logic             frame_full
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_mask;
    logic [7:0]       w_mask_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [7:0]       r_load;
    logic [7:0]       w_load_nxt;
    logic [WIDTH-1:0] r_lane [8];

    logic             w_accept;
    logic [2:0]       w_lane_sel;
    logic [7:0]       w_lane_hot;

    // Handshake and lane decode; frame_full is the visible copy of the FSM state.
    assign in_ready   = (r_state == FILL);
    assign w_accept   = in_valid && in_ready;
    assign w_lane_sel = auto ? r_ptr : sel;
    assign w_lane_hot = 8'b0000_0001 << w_lane_sel;

    // Next-state logic: fill the mask on accepts, wait for ack once complete.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_ptr_nxt   = r_ptr;
        w_load_nxt  = 8'h00;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_load_nxt = w_lane_hot;
                    w_mask_nxt = r_mask | w_lane_hot;
                    if (auto) begin
                        w_ptr_nxt = r_ptr + 3'd1;
                    end
                    if ((r_mask | w_lane_hot) == 8'hFF) begin
                        w_state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (frame_ack) begin
                    w_state_nxt = FILL;
                    w_mask_nxt  = 8'h00;
                    w_ptr_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // State, mask, pointer and strobe registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_mask  <= 8'h00;
            r_ptr   <= 3'd0;
            r_load  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_ptr   <= w_ptr_nxt;
            r_load  <= w_load_nxt;
        end
    end

    // Lane storage: only the addressed lane captures on an accept; ack leaves data intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                r_lane[k] <= '0;
            end
        end else if (w_accept) begin
            r_lane[w_lane_sel] <= in;
        end
    end

    assign a          = r_lane[0];
    assign b          = r_lane[1];
    assign c          = r_lane[2];
    assign d          = r_lane[3];
    assign e          = r_lane[4];
    assign f          = r_lane[5];
    assign g          = r_lane[6];
    assign h          = r_lane[7];
    assign load       = r_load;
    assign ptr        = r_ptr;
    assign frame_full = (r_state == FULL);

endmodule

// File: tb/tb_dmux8way16_frame.sv
// Bench for dmux8way16_frame: directed test-plan sequences plus random traffic,
// all compared against a frame-level reference model kept in this file.
module tb_dmux8way16_frame;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   sel;
    logic         auto;
    logic         frame_ack;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]   load;
    logic [2:0]   ptr;
    logic         frame_full;

    dmux8way16_frame #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .auto       (auto),
        .frame_ack  (frame_ack),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .h          (h),
        .load       (load),
        .ptr        (ptr),
        .frame_full (frame_full)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] dut_lane [8];
    assign dut_lane[0] = a;
    assign dut_lane[1] = b;
    assign dut_lane[2] = c;
    assign dut_lane[3] = d;
    assign dut_lane[4] = e;
    assign dut_lane[5] = f;
    assign dut_lane[6] = g;
    assign dut_lane[7] = h;

    int errors = 0;
    int checks = 0;

    // reference model: lane contents, set of lanes written this frame, pointer
    logic [W-1:0] m_lane [8];
    bit           m_written [8];
    int           m_ptr;
    bit           m_full;
    int           m_load_lane;   // -1 when no lane was written last cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int written_count();
        int n = 0;
        for (int k = 0; k < 8; k++) n += m_written[k] ? 1 : 0;
        return n;
    endfunction

    task automatic model_step(input logic v, input logic au, input logic [2:0] s,
                              input logic [W-1:0] dat, input logic ack, input logic rst);
        int lane;
        m_load_lane = -1;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_lane[k]    = '0;
                m_written[k] = 0;
            end
            m_ptr  = 0;
            m_full = 0;
        end else if (m_full) begin
            if (ack) begin
                for (int k = 0; k < 8; k++) m_written[k] = 0;
                m_ptr  = 0;
                m_full = 0;
            end
        end else if (v) begin
            lane            = au ? m_ptr : int'(s);
            m_lane[lane]    = dat;
            m_written[lane] = 1;
            m_load_lane     = lane;
            if (au) m_ptr = (m_ptr + 1) % 8;
            if (written_count() == 8) m_full = 1;
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_load;
        exp_load = 8'h00;
        if (m_load_lane >= 0) exp_load[m_load_lane] = 1'b1;
        for (int k = 0; k < 8; k++) chk($sformatf("lane%0d", k), 32'(dut_lane[k]), 32'(m_lane[k]));
        chk("load", 32'(load), 32'(exp_load));
        chk("ptr", 32'(ptr), 32'(m_ptr));
        chk("frame_full", 32'(frame_full), 32'(m_full));
        chk("in_ready", 32'(in_ready), 32'(!m_full));
    endtask

    // drive one cycle of inputs, advance model and DUT, compare #1 after the edge
    task automatic step(input logic v, input logic au, input logic [2:0] s,
                        input logic [W-1:0] dat, input logic ack, input logic rst);
        in_valid  = v;
        auto      = au;
        sel       = s;
        in        = dat;
        frame_ack = ack;
        reset     = rst;
        model_step(v, au, s, dat, ack, rst);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [7:0]   exp_load;
        logic [2:0]   exp_ptr;
        logic         exp_full;
    } fill_vec_t;

    fill_vec_t    fill_vec [8];
    logic [W-1:0] words [8];

    initial begin
        fill_vec[0] = '{16'hAAAA, 8'h01, 3'd1, 1'b0};
        fill_vec[1] = '{16'h0000, 8'h02, 3'd2, 1'b0};
        fill_vec[2] = '{16'h1111, 8'h04, 3'd3, 1'b0};
        fill_vec[3] = '{16'h4444, 8'h08, 3'd4, 1'b0};
        fill_vec[4] = '{16'hCCCC, 8'h10, 3'd5, 1'b0};
        fill_vec[5] = '{16'hFFFF, 8'h20, 3'd6, 1'b0};
        fill_vec[6] = '{16'hDDDD, 8'h40, 3'd7, 1'b0};
        fill_vec[7] = '{16'hEEEE, 8'h80, 3'd0, 1'b1};

        in = '0; in_valid = 0; sel = '0; auto = 0; frame_ack = 0; reset = 1;
        for (int k = 0; k < 8; k++) begin
            m_lane[k] = '1;
            m_written[k] = 0;
        end
        m_ptr = 0; m_full = 0; m_load_lane = -1;
        @(posedge clk);
        #1;
        // reset state
        step(0, 0, 0, 16'h0000, 0, 1);

        // auto fill from the vector table
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, fill_vec[i].din, 0, 0);
            chk($sformatf("fill%0d_load", i), 32'(load), 32'(fill_vec[i].exp_load));
            chk($sformatf("fill%0d_ptr", i), 32'(ptr), 32'(fill_vec[i].exp_ptr));
            chk($sformatf("fill%0d_full", i), 32'(frame_full), 32'(fill_vec[i].exp_full));
        end
        for (int k = 0; k < 8; k++) chk($sformatf("fill_lane%0d", k), 32'(dut_lane[k]), 32'(fill_vec[k].din));
        chk("fill_ready_low", 32'(in_ready), 32'd0);

        // stall while full, then ack
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 16'h1234, 0, 0);
            chk("stall_load", 32'(load), 32'd0);
            chk("stall_a", 32'(a), 32'hAAAA);
        end
        step(0, 1, 0, 16'h1234, 1, 0);
        chk("ack_ready", 32'(in_ready), 32'd1);
        chk("ack_full", 32'(frame_full), 32'd0);
        chk("ack_h_kept", 32'(h), 32'hEEEE);
        step(1, 1, 0, 16'h5555, 0, 0);
        chk("post_ack_a", 32'(a), 32'h5555);
        chk("post_ack_load", 32'(load), 32'h01);

        // manual select with overwrite: full only on the 9th accept
        step(0, 0, 0, 16'h0000, 0, 1);
        step(1, 0, 3, 16'h4444, 0, 0);
        step(1, 0, 3, 16'hBEEF, 0, 0);
        chk("man_restrobe", 32'(load), 32'h08);
        step(1, 0, 0, 16'h0A0A, 0, 0);
        step(1, 0, 1, 16'h0B0B, 0, 0);
        step(1, 0, 2, 16'h0C0C, 0, 0);
        step(1, 0, 4, 16'h0E0E, 0, 0);
        step(1, 0, 5, 16'h0F0F, 0, 0);
        step(1, 0, 6, 16'h1010, 0, 0);
        chk("man_8th_not_full", 32'(frame_full), 32'd0);
        step(1, 0, 7, 16'h2020, 0, 0);
        chk("man_9th_full", 32'(frame_full), 32'd1);
        chk("man_d", 32'(d), 32'hBEEF);
        chk("man_ptr", 32'(ptr), 32'd0);
        step(0, 0, 0, 16'h0000, 1, 0);

        // mixed mode
        step(0, 0, 0, 16'h0000, 0, 1);
        step(1, 1, 0, 16'h1111, 0, 0);
        step(1, 0, 5, 16'h5555, 0, 0);
        step(1, 1, 0, 16'h2222, 0, 0);
        chk("mix_a", 32'(a), 32'h1111);
        chk("mix_f", 32'(f), 32'h5555);
        chk("mix_b", 32'(b), 32'h2222);
        chk("mix_ptr", 32'(ptr), 32'd2);

        // reset mid-frame with a valid word on the reset edge
        step(0, 0, 0, 16'h0000, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h7000 + 16'(i), 0, 0);
        step(1, 1, 0, 16'h9999, 0, 1);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_lane%0d", k), 32'(dut_lane[k]), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_full", 32'(frame_full), 32'd0);

        // valid gaps
        for (int i = 0; i < 8; i++) begin
            words[i] = W'($urandom);
            step(1, 1, 0, words[i], 0, 0);
            if (i < 7) begin
                step(0, 1, 0, 16'hDEAD, 0, 0);
                chk("gap_load", 32'(load), 32'd0);
                chk("gap_not_full", 32'(frame_full), 32'd0);
            end
        end
        for (int k = 0; k < 8; k++) chk($sformatf("gap_lane%0d", k), 32'(dut_lane[k]), 32'(words[k]));
        chk("gap_full", 32'(frame_full), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmux8way16_frame.md
Name: dmux8way16_frame

Overview:
- Registered 1-to-8 word distributor; the write-side counterpart of the 8-way 16-bit read mux.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and steers each word into one of eight held output lanes a..h.
- Lane selection is either an auto-incrementing pointer or an explicit per-word selector.
- Signals frame-full once all eight distinct lanes are written, then stalls until the consumer acknowledges.
- Feeds register-bank and RAM8-style loaders that pair with the Mux8Way16 read path.

Parameters:
WIDTH, 16, data width of the input word and of each output lane

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in  input  WIDTH  data word
in_valid  input  1  word on `in` is valid this cycle
in_ready  output  1  block can accept a word this cycle
sel  input  3  target lane for the word when auto=0
auto  input  1  1: lane = internal pointer; 0: lane = sel
frame_ack  input  1  consumer has taken the full frame
a,b,c,d,e,f,g,h  output  WIDTH each  registered lane contents (a = lane 0 ... h = lane 7)
load  output  8  one-hot strobe: bit k high for one cycle when lane k was updated
ptr  output  3  current auto pointer
frame_full  output  1  all eight lanes written since the last ack/reset

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-high.
  - Reset has priority over every other input.
- Reset values:
  - a..h = 0, load = 0, ptr = 0, frame_full = 0.
  - Internal written-mask = 0; state = FILL.
- States: FILL, FULL.
- in_ready:
  - Combinational: 1 in FILL, 0 in FULL.
  - An accept is ignored in any cycle where reset = 1.
- Accept:
  - Occurs on a rising edge with in_valid=1, in_ready=1 and reset=0.
  - Target lane L = ptr if auto=1, else sel.
- Effects of an accept at edge N (visible after edge N):
  - Lane L holds `in`; all other lanes hold their values.
  - load = one-hot(L) for exactly one cycle.
  - mask[L] set.
  - If auto=1: ptr = ptr+1 mod 8, so 7 wraps to 0. If auto=0: ptr unchanged.
- No accept: load = 0; all lanes hold.
- Write latency: one cycle from accept edge to lane/strobe update.
- FILL -> FULL:
  - Transition at the accept edge that makes mask = 8'hFF.
  - frame_full goes 1 in the same cycle as that final load strobe.
- FULL:
  - in_ready = 0; in_valid is ignored; lanes hold.
  - frame_full stays 1 until frame_ack.
- FULL + frame_ack=1 at edge:
  - Next state FILL; mask = 0; ptr = 0; frame_full = 0.
  - Lanes keep their data; they are not cleared.
- frame_ack in FILL: ignored.
- Manual-mode boundary:
  - Rewriting an already-written lane overwrites its data and re-strobes load.
  - The mask is unchanged, so the frame completes only when all 8 distinct lanes have been written.
- auto toggled mid-frame: the pointer resumes from its current value. If that lane is already written, it is overwritten.
- Reset mid-frame: takes effect at the next edge. Partial data is discarded and lanes are zeroed, even with in_valid=1 on that edge.
- Word-to-lane mapping: in, lanes and comparisons are all WIDTH bits; no truncation or extension.

Test Plan:
- Auto fill:
  - Stimulus: after reset, auto=1, in_valid=1, words AAAA,0000,1111,4444,CCCC,FFFF,DDDD,EEEE on consecutive cycles.
  - Required: a..h hold those values in order; load walks 01,02,...,80; frame_full=1 with the 8th strobe; in_ready=0 next cycle; ptr=0.
- Stall and ack:
  - Stimulus: from FULL, hold in_valid=1 with 1234 for 3 cycles, then pulse frame_ack.
  - Required: no lane changes and load=0 during the stall; after ack, in_ready=1, frame_full=0, ptr=0, lanes unchanged.
  - Follow-on: next word 5555 lands in a.
- Manual select with overwrite:
  - Stimulus: auto=0, writes sel=3:4444, sel=3:BEEF, then sel=0,1,2,4,5,6,7.
  - Required: d=BEEF; frame_full rises only on the sel=7 write (9th accept), not the 8th.
- Mixed mode:
  - Stimulus: auto=1 write 1111 (ptr 0->1); auto=0 sel=5 write 5555; auto=1 write 2222.
  - Required: a=1111, f=5555, b=2222; ptr=2.
- Reset mid-frame:
  - Stimulus: after 4 auto writes, assert reset for one cycle while in_valid=1.
  - Required: all lanes 0, ptr=0, mask clear, frame_full=0, load=0; the word present during reset is not captured.
- Valid gaps:
  - Stimulus: auto fill with in_valid deasserted on alternating cycles.
  - Required: lanes fill in order a..h regardless of gaps; load=0 on idle cycles; frame_full after the 8th accepted word.
